// File: rtl/hv_stream_packer.sv
// Serialises finished hypervectors into DW-bit AXI-Stream beats through a two-entry ping-pong buffer.
// Counts vectors per job, flags the final beat with dst_last and pulses done once the job drains.
module hv_stream_packer #(
    parameter int unsigned HV_W  = 1024,
    parameter int unsigned DW    = 64,
    parameter int unsigned CNT_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  vec_total,
    input  logic              in_valid,
    input  logic [HV_W-1:0]   in_data,
    output logic              in_ready,
    output logic [DW-1:0]     dst_data,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic              dst_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BEATS = HV_W / DW;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Each entry viewed as BEATS slices so slice k is in_data[k*DW +: DW].
    logic [BEATS-1:0][DW-1:0] mem [2];

    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       entries;
    logic [BW-1:0]    beat_idx;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] vec_sent;
    logic [CNT_W-1:0] vec_accepted;

    logic push;
    logic pop;
    logic beat_hs;
    logic last_beat;
    logic last_vec;

    // Handshake decode
    always_comb begin
        beat_hs   = dst_valid && dst_ready;
        last_beat = (beat_idx == BW'(BEATS - 1));
        last_vec  = (vec_sent == (total_q - CNT_W'(1)));
        pop       = beat_hs && last_beat;
        push      = in_valid && in_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (vec_total == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (pop && last_vec) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; all terms come from registered state, no input-to-output paths.
    always_comb begin
        in_ready  = 1'b0;
        dst_valid = 1'b0;
        dst_data  = '0;
        dst_last  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == FIN);
        if (state == RUN) begin
            in_ready  = (entries < 2'd2) && (vec_accepted < total_q);
            dst_valid = (entries != 2'd0);
        end
        if (dst_valid) begin
            dst_data = mem[rd_ptr][beat_idx];
            dst_last = last_beat && last_vec;
        end
    end

    // Buffer bookkeeping and job counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            entries      <= 2'd0;
            beat_idx     <= '0;
            total_q      <= '0;
            vec_sent     <= '0;
            vec_accepted <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                total_q      <= vec_total;
                vec_sent     <= '0;
                vec_accepted <= '0;
                beat_idx     <= '0;
            end
            if (push) begin
                wr_ptr       <= ~wr_ptr;
                vec_accepted <= vec_accepted + CNT_W'(1);
            end
            if (beat_hs) begin
                beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                vec_sent <= vec_sent + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   entries <= entries + 2'd1;
                2'b01:   entries <= entries - 2'd1;
                default: entries <= entries;
            endcase
        end
    end

    // Vector storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_hv_stream_packer.sv
// Bench for hv_stream_packer: directed job sequence with random data and handshakes,
// compared every cycle against a vector-queue model of the packer.
module tb_hv_stream_packer;

    localparam int unsigned HV_W  = 1024;
    localparam int unsigned DW    = 64;
    localparam int unsigned CNT_W = 30;
    localparam int unsigned BEATS = HV_W / DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  vec_total;
    logic              in_valid;
    logic [HV_W-1:0]   in_data;
    logic              in_ready;
    logic [DW-1:0]     dst_data;
    logic              dst_valid;
    logic              dst_ready;
    logic              dst_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    hv_stream_packer #(.HV_W(HV_W), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_total (vec_total),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_last  (dst_last),
        .busy      (busy),
        .done      (done)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a job flag, vector counters and the queue of buffered vectors.
    bit              m_ok  = 1'b0;
    bit              m_run = 1'b0;
    bit              m_fin = 1'b0;
    longint          m_total = 0;
    longint          m_acc   = 0;
    longint          m_sent  = 0;
    int              m_beat  = 0;
    logic [HV_W-1:0] vq[$];

    int push_cnt = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    logic [HV_W-1:0] v1;
    logic [HV_W-1:0] v2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < int'(HV_W / 32); i++) begin
            in_data[i*32 +: 32] = $urandom;
        end
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cyc();
        logic            e_ir;
        logic            e_v;
        logic            e_l;
        logic [DW-1:0]   e_d;
        logic [HV_W-1:0] head;
        bit              p;
        bit              q;
        e_ir = m_run && (vq.size() < 2) && (m_acc < m_total);
        e_v  = m_run && (vq.size() > 0);
        e_d  = '0;
        if (e_v) begin
            head = vq[0];
            e_d  = head[m_beat*DW +: DW];
        end
        e_l = e_v && (m_beat == int'(BEATS) - 1) && (m_sent == m_total - 1);
        if (m_ok) begin
            chk("in_ready",  64'(in_ready),  64'(e_ir));
            chk("dst_valid", 64'(dst_valid), 64'(e_v));
            chk("dst_data",  64'(dst_data),  64'(e_d));
            chk("dst_last",  64'(dst_last),  64'(e_l));
            chk("busy",      64'(busy),      64'(m_run || m_fin));
            chk("done",      64'(done),      64'(m_fin));
        end
        if (in_valid && in_ready) push_cnt++;
        if (dst_valid && dst_ready) hs_cnt++;
        if (done) done_cnt++;
        if (!rst) begin
            m_ok = 1'b1; m_run = 1'b0; m_fin = 1'b0;
            vq.delete();
            m_beat = 0; m_sent = 0; m_acc = 0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_total = longint'(vec_total);
                m_acc = 0; m_sent = 0; m_beat = 0;
                if (vec_total == '0) m_fin = 1'b1;
                else m_run = 1'b1;
            end
        end else begin
            p = e_v && dst_ready;
            q = in_valid && e_ir;
            if (p) begin
                m_beat++;
                if (m_beat == int'(BEATS)) begin
                    m_beat = 0;
                    void'(vq.pop_front());
                    m_sent++;
                    if (m_sent == m_total) begin
                        m_run = 1'b0;
                        m_fin = 1'b1;
                    end
                end
            end
            if (q) begin
                vq.push_back(in_data);
                m_acc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_job(input logic [CNT_W-1:0] vt);
        start     = 1'b1;
        vec_total = vt;
        in_valid  = 1'b0;
        dst_ready = 1'b0;
        cyc();
        start = 1'b0;
    endtask

    // rmode: 0 ready held, 1 toggling, 2 random (plus stray starts); vmode: 0 valid held, 1 random
    task automatic run_job(input int limit, input int rmode, input int vmode, input bit rdata);
        int n;
        n = 0;
        done_cnt = 0;
        while (done_cnt == 0 && n < limit) begin
            dst_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? n[0] : 1'($urandom_range(0, 1));
            in_valid  = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start     = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rdata) rand_data();
            cyc();
            n++;
        end
        chk("job_done_seen", 64'(done_cnt), 64'd1);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; dst_ready = 1'b0;
        vec_total = CNT_W'(5); in_data = '0;
        @(negedge clk);

        // Reset held with start and in_valid asserted
        repeat (3) cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        cyc();

        // Single vector with a per-beat pattern
        for (int k = 0; k < int'(BEATS); k++) begin
            v1[k*DW +: DW] = {8{8'(k)}} ^ 64'hA5A5_0000_5A5A_FFFF;
        end
        push_cnt = 0; hs_cnt = 0;
        start_job(CNT_W'(1));
        in_data = v1;
        run_job(100, 0, 0, 1'b0);
        chk("single_pushes", 64'(push_cnt), 64'd1);
        chk("single_beats",  64'(hs_cnt),   64'd16);
        cyc();
        chk("single_idle_busy", 64'(busy), 64'd0);

        // Backpressure: toggling ready, valid held, three vectors
        push_cnt = 0; hs_cnt = 0;
        start_job(CNT_W'(3));
        run_job(400, 1, 0, 1'b1);
        chk("bp_pushes", 64'(push_cnt), 64'd3);
        chk("bp_beats",  64'(hs_cnt),   64'd48);
        cyc();

        // Zero-length job with valid held
        in_valid = 1'b1;
        start_job(CNT_W'(0));
        in_valid = 1'b1;
        chk("zero_done", 64'(done), 64'd1);
        cyc();
        chk("zero_done_clear", 64'(done), 64'd0);
        in_valid = 1'b0;
        cyc();

        // Reset in the middle of a four-vector job
        hs_cnt = 0;
        start_job(CNT_W'(4));
        n = 0;
        while (hs_cnt < 20 && n < 500) begin
            dst_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            rand_data();
            cyc();
            n++;
        end
        chk("midrst_reached", 64'(hs_cnt), 64'd20);
        rst = 1'b0; in_valid = 1'b0; dst_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_dst_valid", 64'(dst_valid), 64'd0);
        chk("midrst_dst_data",  64'(dst_data),  64'd0);
        hs_cnt = 0; done_cnt = 0;
        cyc();
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        start_job(CNT_W'(1));
        run_job(100, 0, 0, 1'b1);
        chk("midrst_clean_beats", 64'(hs_cnt), 64'd16);
        cyc();

        // Push on the same cycle as the final beat of the only buffered vector
        for (int i = 0; i < int'(HV_W / 32); i++) begin
            v1[i*32 +: 32] = $urandom;
            v2[i*32 +: 32] = $urandom;
        end
        start_job(CNT_W'(2));
        in_valid = 1'b1; in_data = v1; dst_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!(m_beat == int'(BEATS) - 1 && vq.size() == 1) && n < 40) begin
            cyc();
            n++;
        end
        chk("pp_at_last_beat", 64'(dst_last || (m_beat == int'(BEATS) - 1)), 64'd1);
        in_valid = 1'b1; in_data = v2;
        cyc();
        in_valid = 1'b0;
        chk("pp_valid", 64'(dst_valid), 64'd1);
        chk("pp_beat0", 64'(dst_data),  v2[63:0]);
        cyc();
        chk("pp_beat1", 64'(dst_data),  v2[127:64]);
        run_job(100, 0, 1, 1'b1);
        cyc();

        // Random jobs with random handshakes and stray start pulses
        for (int j = 0; j < 6; j++) begin
            push_cnt = 0;
            start_job(CNT_W'($urandom_range(1, 5)));
            run_job(2000, 2, 1, 1'b1);
            chk("rand_pushes", 64'(push_cnt), 64'(m_total));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
